// File: rtl/seq_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module : seq_rx_pkg
// Brief  : Symbol constants, successor function and state codes for seq_rx.
// Rev    : 1.0
// ============================================================================
package seq_rx_pkg;

    localparam logic [1:0] SYM_A = 2'b01;
    localparam logic [1:0] SYM_B = 2'b10;
    localparam logic [1:0] SYM_C = 2'b11;
    localparam logic [1:0] SYM_D = 2'b00;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2,
        ST_SLIP = 2'd3
    } state_e;

    localparam int ENC_BINARY     = 0;
    localparam int ENC_ONEHOT     = 1;
    localparam int ENC_INV_ONEHOT = 2;

    function automatic logic [1:0] next_sym(input logic [1:0] s);
        case (s)
            SYM_A:   return SYM_B;
            SYM_B:   return SYM_C;
            SYM_C:   return SYM_D;
            default: return SYM_A;
        endcase
    endfunction

    // Register code for a state; all encodings fit in 4 bits.
    function automatic logic [3:0] state_code(input int enc, input state_e s);
        logic [3:0] oh;
        case (s)
            ST_HUNT: oh = 4'b0001;
            ST_ACQ:  oh = 4'b0010;
            ST_LOCK: oh = 4'b0100;
            default: oh = 4'b1000;
        endcase
        case (enc)
            ENC_ONEHOT:     return oh;
            ENC_INV_ONEHOT: return ~oh;
            default:        return {2'b00, s};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_rx_monitor_if.sv
`default_nettype none
// ============================================================================
// Module : seq_rx_monitor_if
// Brief  : Symbol input / monitor status bundle for seq_rx_monitor.
// Rev    : 1.0
// ============================================================================
interface seq_rx_monitor_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [1:0]       in_sym;
    logic             clr_cnt;
    logic             locked;
    logic             err;
    logic [1:0]       expected;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, in_sym, clr_cnt,
        input  locked, err, expected, err_cnt
    );

    modport slave (
        input  in_valid, in_sym, clr_cnt,
        output locked, err, expected, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/seq_rx_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Saturating up-counter; clear wins over a coincident increment.
// Rev    : 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;
endmodule
`default_nettype wire

// File: rtl/seq_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module : seq_rx_monitor
// Brief  : Hunts, locks and flywheels on the 01->10->11->00 symbol cycle.
// Rev    : 1.0
// ============================================================================
module seq_rx_monitor
    import seq_rx_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_LIMIT  = 2,
    parameter int CNT_W      = 8,
    parameter int STATE_ENC  = 0
) (
    input  logic             clk,
    input  logic             rst,
    seq_rx_monitor_if.slave  bus
);
    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(ERR_LIMIT + 1);

    localparam logic [3:0] c_hunt = state_code(STATE_ENC, ST_HUNT);
    localparam logic [3:0] c_acq  = state_code(STATE_ENC, ST_ACQ);
    localparam logic [3:0] c_lock = state_code(STATE_ENC, ST_LOCK);
    localparam logic [3:0] c_slip = state_code(STATE_ENC, ST_SLIP);

    logic [3:0]        r_state;
    logic [1:0]        r_expected;
    logic [RUN_W-1:0]  r_run;
    logic [MISS_W-1:0] r_miss;
    logic              r_locked;
    logic              r_err;

    state_e            w_state;
    state_e            w_state_nxt;
    logic              w_illegal;
    logic              w_match;
    logic [1:0]        w_exp_nxt;
    logic [RUN_W-1:0]  w_run_nxt;
    logic [MISS_W-1:0] w_miss_nxt;
    logic              w_err_nxt;
    logic [CNT_W-1:0]  w_cnt;

    // Any code outside the four legal ones is treated as illegal and forced to HUNT.
    always_comb begin
        w_state   = ST_HUNT;
        w_illegal = 1'b0;
        if (r_state == c_hunt)      w_state = ST_HUNT;
        else if (r_state == c_acq)  w_state = ST_ACQ;
        else if (r_state == c_lock) w_state = ST_LOCK;
        else if (r_state == c_slip) w_state = ST_SLIP;
        else                        w_illegal = 1'b1;
    end

    assign w_match = (bus.in_sym == r_expected);

    always_comb begin
        w_state_nxt = w_state;
        w_exp_nxt   = r_expected;
        w_run_nxt   = r_run;
        w_miss_nxt  = r_miss;
        w_err_nxt   = 1'b0;
        if (w_illegal) begin
            w_state_nxt = ST_HUNT;
        end else if (bus.in_valid) begin
            case (w_state)
                ST_HUNT: begin
                    w_exp_nxt   = next_sym(bus.in_sym);
                    w_run_nxt   = RUN_W'(1);
                    w_state_nxt = ST_ACQ;
                end
                ST_ACQ: begin
                    w_exp_nxt = next_sym(bus.in_sym);
                    if (w_match) begin
                        w_run_nxt = r_run + RUN_W'(1);
                        if (int'(r_run) + 1 == LOCK_COUNT) w_state_nxt = ST_LOCK;
                    end else begin
                        w_run_nxt = RUN_W'(1);
                    end
                end
                ST_LOCK: begin
                    // Flywheel: once locked, the prediction advances from itself, never from the input.
                    w_exp_nxt = next_sym(r_expected);
                    if (w_match) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_miss_nxt  = MISS_W'(1);
                        w_state_nxt = (ERR_LIMIT == 1) ? ST_HUNT : ST_SLIP;
                    end
                end
                default: begin
                    w_exp_nxt = next_sym(r_expected);
                    if (w_match) begin
                        w_miss_nxt  = '0;
                        w_state_nxt = ST_LOCK;
                    end else begin
                        w_err_nxt  = 1'b1;
                        w_miss_nxt = r_miss + MISS_W'(1);
                        if (int'(r_miss) + 1 == ERR_LIMIT) w_state_nxt = ST_HUNT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_hunt;
            r_expected <= SYM_A;
            r_run      <= '0;
            r_miss     <= '0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= state_code(STATE_ENC, w_state_nxt);
            r_expected <= w_exp_nxt;
            r_run      <= w_run_nxt;
            r_miss     <= w_miss_nxt;
            r_locked   <= (w_state_nxt == ST_LOCK) || (w_state_nxt == ST_SLIP);
            r_err      <= w_err_nxt;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_err_nxt),
        .clr (bus.clr_cnt),
        .cnt (w_cnt)
    );

    assign bus.locked   = r_locked;
    assign bus.err      = r_err;
    assign bus.expected = r_expected;
    assign bus.err_cnt  = w_cnt;
endmodule
`default_nettype wire

// File: tb/tb_seq_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module : tb_seq_rx_monitor
// Brief  : Vector table plus random stream against a reference model, four builds.
// Rev    : 1.0
// ============================================================================
module tb_seq_rx_monitor;
    localparam int NDUT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       t_valid = 1'b0;
    logic [1:0] t_sym = 2'b00;
    logic       t_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_rx_monitor_if #(.CNT_W(2)) if0 ();
    seq_rx_monitor_if #(.CNT_W(2)) if1 ();
    seq_rx_monitor_if #(.CNT_W(2)) if2 ();
    seq_rx_monitor_if #(.CNT_W(8)) if3 ();

    assign if0.in_valid = t_valid; assign if0.in_sym = t_sym; assign if0.clr_cnt = t_clr;
    assign if1.in_valid = t_valid; assign if1.in_sym = t_sym; assign if1.clr_cnt = t_clr;
    assign if2.in_valid = t_valid; assign if2.in_sym = t_sym; assign if2.clr_cnt = t_clr;
    assign if3.in_valid = t_valid; assign if3.in_sym = t_sym; assign if3.clr_cnt = t_clr;

    seq_rx_monitor #(.LOCK_COUNT(4), .ERR_LIMIT(2), .CNT_W(2), .STATE_ENC(0))
        d0 (.clk(clk), .rst(rst), .bus(if0));
    seq_rx_monitor #(.LOCK_COUNT(4), .ERR_LIMIT(2), .CNT_W(2), .STATE_ENC(1))
        d1 (.clk(clk), .rst(rst), .bus(if1));
    seq_rx_monitor #(.LOCK_COUNT(4), .ERR_LIMIT(2), .CNT_W(2), .STATE_ENC(2))
        d2 (.clk(clk), .rst(rst), .bus(if2));
    seq_rx_monitor #(.LOCK_COUNT(3), .ERR_LIMIT(1), .CNT_W(8), .STATE_ENC(1))
        d3 (.clk(clk), .rst(rst), .bus(if3));

    logic       a_locked [NDUT];
    logic       a_err    [NDUT];
    logic [1:0] a_exp    [NDUT];
    logic [7:0] a_cnt    [NDUT];

    assign a_locked[0] = if0.locked; assign a_err[0] = if0.err; assign a_exp[0] = if0.expected; assign a_cnt[0] = 8'(if0.err_cnt);
    assign a_locked[1] = if1.locked; assign a_err[1] = if1.err; assign a_exp[1] = if1.expected; assign a_cnt[1] = 8'(if1.err_cnt);
    assign a_locked[2] = if2.locked; assign a_err[2] = if2.err; assign a_exp[2] = if2.expected; assign a_cnt[2] = 8'(if2.err_cnt);
    assign a_locked[3] = if3.locked; assign a_err[3] = if3.err; assign a_exp[3] = if3.expected; assign a_cnt[3] = 8'(if3.err_cnt);

    // Reference model: the symbol cycle is just "add one modulo four".
    int p_lc   [NDUT] = '{4, 4, 4, 3};
    int p_el   [NDUT] = '{2, 2, 2, 1};
    int p_cmax [NDUT] = '{3, 3, 3, 255};

    int m_exp [NDUT];
    int m_run [NDUT];
    int m_miss[NDUT];
    int m_cnt [NDUT];
    bit m_locked[NDUT];
    bit m_seeded[NDUT];
    bit m_err   [NDUT];

    function automatic int nxt(input int s);
        return (s + 1) % 4;
    endfunction

    task automatic model_step();
        for (int k = 0; k < NDUT; k++) begin
            if (rst) begin
                m_exp[k] = 1; m_run[k] = 0; m_miss[k] = 0; m_cnt[k] = 0;
                m_locked[k] = 0; m_seeded[k] = 0; m_err[k] = 0;
            end else begin
                m_err[k] = 0;
                if (t_valid) begin
                    if (m_locked[k]) begin
                        if (int'(t_sym) == m_exp[k]) begin
                            m_miss[k] = 0;
                        end else begin
                            m_err[k] = 1;
                            m_miss[k]++;
                            if (m_miss[k] >= p_el[k]) begin
                                m_locked[k] = 0;
                                m_seeded[k] = 0;
                            end
                        end
                        m_exp[k] = nxt(m_exp[k]);
                    end else if (m_seeded[k] && int'(t_sym) == m_exp[k]) begin
                        m_run[k]++;
                        m_exp[k] = nxt(int'(t_sym));
                        if (m_run[k] == p_lc[k]) begin
                            m_locked[k] = 1;
                            m_miss[k] = 0;
                        end
                    end else begin
                        m_seeded[k] = 1;
                        m_run[k] = 1;
                        m_exp[k] = nxt(int'(t_sym));
                    end
                end
                if (t_clr) m_cnt[k] = 0;
                else if (m_err[k] && m_cnt[k] < p_cmax[k]) m_cnt[k]++;
            end
        end
    endtask

    task automatic chk(input string nm, input int k, input int cyc, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s dut%0d cyc%0d: got %0d want %0d", nm, k, cyc, got, want);
        end
    endtask

    task automatic chk_model(input int cyc);
        for (int k = 0; k < NDUT; k++) begin
            chk("model_locked", k, cyc, int'(a_locked[k]), int'(m_locked[k]));
            chk("model_err",    k, cyc, int'(a_err[k]),    int'(m_err[k]));
            chk("model_exp",    k, cyc, int'(a_exp[k]),    m_exp[k]);
            chk("model_cnt",    k, cyc, int'(a_cnt[k]),    m_cnt[k]);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       v;
        logic [1:0] sym;
        logic       clr;
        logic       lk;
        logic       er;
        logic [1:0] ex;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic v, input logic [1:0] s, input logic c,
                       input logic lk, input logic er, input logic [1:0] ex, input int cnt);
        vec_t e;
        e.rst = r; e.v = v; e.sym = s; e.clr = c;
        e.lk = lk; e.er = er; e.ex = ex; e.cnt = cnt;
        tbl.push_back(e);
    endtask

    initial begin
        // rst valid sym clr | locked err expected err_cnt  (LOCK_COUNT=4, ERR_LIMIT=2, CNT_W=2)
        add(1,0,2'b00,0, 0,0,2'b01,0);
        add(0,1,2'b01,0, 0,0,2'b10,0);
        add(0,1,2'b10,0, 0,0,2'b11,0);
        add(0,0,2'b11,0, 0,0,2'b11,0);
        add(0,1,2'b11,0, 0,0,2'b00,0);
        add(0,1,2'b00,0, 1,0,2'b01,0);
        add(0,1,2'b01,0, 1,0,2'b10,0);
        add(0,1,2'b10,0, 1,0,2'b11,0);
        add(0,1,2'b00,0, 1,1,2'b00,1);
        add(0,1,2'b00,0, 1,0,2'b01,1);
        add(0,1,2'b01,0, 1,0,2'b10,1);
        add(0,1,2'b01,0, 1,1,2'b11,2);
        add(0,1,2'b01,0, 0,1,2'b00,3);
        add(0,0,2'b00,0, 0,0,2'b00,3);
        add(0,1,2'b11,0, 0,0,2'b00,3);
        add(0,1,2'b00,0, 0,0,2'b01,3);
        add(0,1,2'b01,0, 0,0,2'b10,3);
        add(0,1,2'b10,0, 1,0,2'b11,3);
        add(0,1,2'b00,1, 1,1,2'b00,0);
        add(0,1,2'b00,0, 1,0,2'b01,0);
        add(0,1,2'b10,0, 1,1,2'b10,1);
        add(0,1,2'b10,0, 1,0,2'b11,1);
        add(0,0,2'b00,1, 1,0,2'b11,0);
        add(1,1,2'b11,0, 0,0,2'b01,0);
        add(0,1,2'b10,0, 0,0,2'b11,0);
        add(0,1,2'b00,0, 0,0,2'b01,0);
        add(0,1,2'b01,0, 0,0,2'b10,0);
        add(0,1,2'b10,0, 0,0,2'b11,0);
        add(0,1,2'b11,0, 1,0,2'b00,0);
        add(0,1,2'b11,0, 1,1,2'b01,1);
        add(0,1,2'b01,0, 1,0,2'b10,1);
        add(0,1,2'b00,0, 1,1,2'b11,2);
        add(0,1,2'b11,0, 1,0,2'b00,2);
        add(0,1,2'b01,0, 1,1,2'b01,3);
        add(0,1,2'b01,0, 1,0,2'b10,3);
        add(0,1,2'b00,0, 1,1,2'b11,3);
        add(0,1,2'b11,0, 1,0,2'b00,3);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; t_valid = tbl[i].v; t_sym = tbl[i].sym; t_clr = tbl[i].clr;
            @(posedge clk);
            model_step();
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk("tbl_locked", k, i, int'(a_locked[k]), int'(tbl[i].lk));
                chk("tbl_err",    k, i, int'(a_err[k]),    int'(tbl[i].er));
                chk("tbl_exp",    k, i, int'(a_exp[k]),    int'(tbl[i].ex));
                chk("tbl_cnt",    k, i, int'(a_cnt[k]),    tbl[i].cnt);
            end
            chk_model(i);
        end

        for (int c = 0; c < 2000; c++) begin
            rst     = ($urandom_range(0, 199) == 0);
            t_valid = ($urandom_range(0, 9) < 8);
            t_clr   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) < 8)
                t_sym = 2'(m_exp[$urandom_range(0, 1) * 3]);
            else
                t_sym = 2'($urandom_range(0, 3));
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk_model(1000 + c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
